mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port 32-bit RAM (tri-state Data, rdEn/wrEn, 8-bit Addr).
- Shares the RAM between the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Drives every RAM control signal and owns the Data bus during writes.
- Sits between the Beta core and RAM; the core never touches RAM pins directly.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_pick.sv | 70 +++++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, port IDs and streak width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_e;

    // Wide enough for MAX_D_STREAK values up to 15.
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the core (master) and the RAM arbiter (slave):
// instruction-fetch port I and load/store port D.
interface mem_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);
    logic              i_req;
    logic [AWIDTH-1:0] i_addr;
    logic              i_ack;
    logic [DWIDTH-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [AWIDTH-1:0] d_addr;
    logic [DWIDTH-1:0] d_wdata;
    logic              d_ack;
    logic [DWIDTH-1:0] d_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ack, i_rdata, d_ack, d_rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ack, i_rdata, d_ack, d_rdata
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Winner selection for the RAM arbiter. Default: D priority with an I starvation guard.
// Define MEM_ARBITER_RR_EN for round-robin between I and D (streak counter removed).
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      grant,
    output arb_port_e winner
);

`ifdef MEM_ARBITER_RR_EN

    // last_q starts at I so the first contested grant after reset goes to D.
    arb_port_e last_q, last_d;

    always_comb begin
        if (i_req && d_req) begin
            winner = (last_q == ARB_PORT_D) ? ARB_PORT_I : ARB_PORT_D;
        end else if (i_req) begin
            winner = ARB_PORT_I;
        end else begin
            winner = ARB_PORT_D;
        end
        last_d = grant ? winner : last_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= ARB_PORT_I;
        end else begin
            last_q <= last_d;
        end
    end

`else

    logic [STREAK_W-1:0] streak_q, streak_d;

    // streak only grows while I is actually waiting, so it never exceeds MAX_D_STREAK.
    always_comb begin
        winner = ARB_PORT_D;
        if (i_req && (!d_req || streak_q == STREAK_W'(MAX_D_STREAK))) begin
            winner = ARB_PORT_I;
        end
        streak_d = streak_q;
        if (grant) begin
            if (winner == ARB_PORT_D && i_req) begin
                streak_d = streak_q + STREAK_W'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port RAM: IDLE -> ACCESS -> RESP per transaction.
// Arbitration policy is selected in mem_arbiter_pick (MEM_ARBITER_RR_EN for round-robin).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 8,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    inout  wire  [DWIDTH-1:0] mem_data
);

    arb_state_e        state_q, state_d;
    arb_port_e         port_q, port_d;
    arb_port_e         winner;
    logic              grant;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;

    assign grant = (state_q == ARB_IDLE) && (bus.i_req || bus.d_req);

    mem_arbiter_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .i_req  (bus.i_req),
        .d_req  (bus.d_req),
        .grant  (grant),
        .winner (winner)
    );

    // Enables default low so they are high for exactly the ACCESS cycle.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    port_d  = winner;
                    state_d = ARB_ACCESS;
                    if (winner == ARB_PORT_D) begin
                        mem_addr_d  = bus.d_addr;
                        mem_rd_en_d = ~bus.d_we;
                        mem_wr_en_d = bus.d_we;
                        wdata_d     = bus.d_wdata;
                    end else begin
                        mem_addr_d  = bus.i_addr;
                        mem_rd_en_d = 1'b1;
                    end
                end
            end
            ARB_ACCESS: begin
                state_d = ARB_RESP;
                if (port_q == ARB_PORT_D) begin
                    d_ack_d = 1'b1;
                    if (mem_rd_en_q) begin
                        d_rdata_d = mem_data;
                    end
                end else begin
                    i_ack_d = 1'b1;
                    if (mem_rd_en_q) begin
                        i_rdata_d = mem_data;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            port_q      <= ARB_PORT_I;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    // RAM only drives Data on rdEn & ~wrEn, so driving here on wrEn alone cannot contend.
    assign mem_data    = mem_wr_en_q ? wdata_q : {DWIDTH{1'bz}};
    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RAM model, reference memory, per-port expectation queues
// and a negedge monitor; covers reset, store/load, reset mid-fetch, grant order and random traffic.
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int MAX = 4;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] data;
    } d_exp_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    wire  [DW-1:0] mem_data;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    logic [DW-1:0]    iq[$];
    d_exp_t           dq[$];
    logic [AW+DW-1:0] exp_wr[$];
    bit               ack_order[$];

    int            compared;
    int            mismatched;
    logic          access_prev;
    logic [DW-1:0] mon_i_hold;
    logic [DW-1:0] mon_d_hold;

    mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    mem_arbiter #(
        .DWIDTH       (DW),
        .AWIDTH       (AW),
        .MAX_D_STREAK (MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_data  (mem_data)
    );

    // Single-port RAM model: drives Data only on rdEn & ~wrEn, writes on wrEn at the edge.
    assign mem_data = (mem_rd_en && !mem_wr_en) ? ram[mem_addr] : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_addr] <= mem_data;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] initWord(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hA5, b, ~b, 8'h3C};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Issues one transaction on a port, records expectations, waits (bounded) for its ack.
    task automatic applyStimulus(input bit is_d, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        logic done;
        d_exp_t e;
        done = 1'b0;
        if (is_d) begin
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_req   = 1'b1;
            if (we) begin
                ref_mem[addr] = wdata;
                exp_wr.push_back({addr, wdata});
                e.we   = 1'b1;
                e.data = '0;
            end else begin
                e.we   = 1'b0;
                e.data = ref_mem[addr];
            end
            dq.push_back(e);
        end else begin
            bus.i_addr = addr;
            bus.i_req  = 1'b1;
            iq.push_back(ref_mem[addr]);
        end
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            done = is_d ? bus.d_ack : bus.i_ack;
        end
        if (!done) begin
            checkOutput(is_d ? "d_ack_timeout" : "i_ack_timeout", {63'b0, done}, 64'd1);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks bus rules each cycle.
    initial begin
        logic [DW-1:0]    ie;
        d_exp_t           de;
        logic [AW+DW-1:0] we_e;
        access_prev = 1'b0;
        mon_i_hold  = '0;
        mon_d_hold  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                access_prev = 1'b0;
                mon_i_hold  = '0;
                mon_d_hold  = '0;
            end else begin
                if (mem_rd_en || mem_wr_en) begin
                    checkOutput("rd_wr_exclusive", {63'b0, mem_rd_en & mem_wr_en}, 64'd0);
                end
                if (mem_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        checkOutput("write_expected", 64'(exp_wr.size()), 64'd1);
                    end else begin
                        we_e = exp_wr.pop_front();
                        checkOutput("wr_addr", 64'(mem_addr), 64'(we_e[AW+DW-1:DW]));
                        checkOutput("wr_data", 64'(mem_data), 64'(we_e[DW-1:0]));
                    end
                end else if (mem_rd_en) begin
                    checkOutput("rd_bus", 64'(mem_data), 64'(ram[mem_addr]));
                end
                if (access_prev || bus.i_ack || bus.d_ack) begin
                    checkOutput("ack_timing", {63'b0, bus.i_ack | bus.d_ack}, {63'b0, access_prev});
                end
                if (bus.i_ack && bus.d_ack) begin
                    checkOutput("single_ack", {63'b0, bus.i_ack & bus.d_ack}, 64'd0);
                end
                if (bus.i_ack) begin
                    ack_order.push_back(1'b0);
                    if (iq.size() == 0) begin
                        checkOutput("i_ack_expected", 64'(iq.size()), 64'd1);
                    end else begin
                        ie = iq.pop_front();
                        checkOutput("i_rdata", 64'(bus.i_rdata), 64'(ie));
                        mon_i_hold = ie;
                    end
                    checkOutput("d_rdata_hold_fetch", 64'(bus.d_rdata), 64'(mon_d_hold));
                end
                if (bus.d_ack) begin
                    ack_order.push_back(1'b1);
                    if (dq.size() == 0) begin
                        checkOutput("d_ack_expected", 64'(dq.size()), 64'd1);
                    end else begin
                        de = dq.pop_front();
                        if (de.we) begin
                            checkOutput("d_rdata_hold_store", 64'(bus.d_rdata), 64'(mon_d_hold));
                        end else begin
                            checkOutput("d_rdata", 64'(bus.d_rdata), 64'(de.data));
                            mon_d_hold = de.data;
                        end
                    end
                    checkOutput("i_rdata_hold_d", 64'(bus.i_rdata), 64'(mon_i_hold));
                end
                access_prev = mem_rd_en | mem_wr_en;
            end
        end
    end

    initial begin
        bit            exp_seq [10];
        int            nd;
        int            ni;
        logic [AW-1:0] a;

        compared    = 0;
        mismatched  = 0;
        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        for (int k = 0; k < 256; k++) begin
            ram[k]     = initWord(k);
            ref_mem[k] = initWord(k);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_rd_en", {63'b0, mem_rd_en}, 64'd0);
        checkOutput("rst_mem_wr_en", {63'b0, mem_wr_en}, 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_i_ack", {63'b0, bus.i_ack}, 64'd0);
        checkOutput("rst_d_ack", {63'b0, bus.d_ack}, 64'd0);
        checkOutput("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
        checkOutput("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
        reset = 1'b1;

        $display("[TB] single store then load back");
        applyStimulus(1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 8'h05, 32'h0);
        bus.d_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h80, 32'h0);
        bus.i_req = 1'b0;

        $display("[TB] reset during fetch ACCESS");
        @(posedge clk);
        #1;
        bus.i_addr = 8'h10;
        bus.i_req  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrd_rd_en", {63'b0, mem_rd_en}, 64'd1);
        checkOutput("midrd_addr", 64'(mem_addr), 64'h10);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        checkOutput("midrd_rst_rd_en", {63'b0, mem_rd_en}, 64'd0);
        checkOutput("midrd_rst_addr", 64'(mem_addr), 64'd0);
        checkOutput("midrd_rst_i_ack", {63'b0, bus.i_ack}, 64'd0);
        checkOutput("midrd_rst_i_rdata", 64'(bus.i_rdata), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("midrd_no_late_ack", {63'b0, bus.i_ack}, 64'd0);
        reset = 1'b1;

        $display("[TB] contested grant order");
        nd = 0;
        ni = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARBITER_RR_EN
            exp_seq[k] = (k % 2 == 0);
`else
            exp_seq[k] = ((k % (MAX + 1)) != MAX);
`endif
            if (exp_seq[k]) nd++;
            else ni++;
        end
        ack_order.delete();
        fork
            begin
                for (int k = 0; k < nd; k++) begin
                    applyStimulus(1'b1, 1'b0, 8'h05, 32'h0);
                end
                bus.d_req = 1'b0;
            end
            begin
                for (int k = 0; k < ni; k++) begin
                    applyStimulus(1'b0, 1'b0, 8'h90 + 8'(k), 32'h0);
                end
                bus.i_req = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        checkOutput("grant_count", 64'(ack_order.size()), 64'd10);
        for (int k = 0; k < 10 && k < ack_order.size(); k++) begin
            checkOutput($sformatf("grant_order_%0d", k), {63'b0, ack_order[k]}, {63'b0, exp_seq[k]});
        end

        $display("[TB] random traffic, 200 transactions");
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    a = 8'h80 | 8'($urandom_range(0, 127));
                    applyStimulus(1'b0, 1'b0, a, 32'h0);
                    bus.i_req = 1'b0;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    a = 8'($urandom_range(0, 127));
                    applyStimulus(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                    bus.d_req = 1'b0;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        checkOutput("iq_drained", 64'(iq.size()), 64'd0);
        checkOutput("dq_drained", 64'(dq.size()), 64'd0);
        checkOutput("wr_drained", 64'(exp_wr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
